// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
//   Shared types and constants for the data SRAM responder:
//   - FSM state encoding (IDLE/BUSY)
//   - stall bus encodings (STOP/NO_STOP)
//   - latched request record (byte enables + write data)
//   - helper to classify a request as a read
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

    typedef enum logic {
        DSRAM_IDLE = 1'b0,
        DSRAM_BUSY = 1'b1
    } dsram_state_e;

    // Stall request levels seen by the pipeline stall controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] wdata;
    } dsram_req_t;

    // en=1 with no byte enables set is a read
    function automatic logic is_read(input logic [3:0] wen);
        return (wen == 4'b0000);
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// -----------------------------------------------------------------------------
// data_sram_responder_if
//   data_sram bus between the EX/MEM stages (master) and the data memory
//   responder (slave).
//   data_sram_en     1   access request this cycle
//   data_sram_wen    4   byte write enables (0000 = read)
//   data_sram_addr   32  byte address
//   data_sram_wdata  32  write data
//   data_sram_rdata  32  registered read data
//   stallreq         1   hold EX while an access is outstanding
// -----------------------------------------------------------------------------
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  stallreq
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output stallreq
    );

endinterface

// File: rtl/data_sram_responder_sram_bytewe.sv
// -----------------------------------------------------------------------------
// sram_bytewe
//   Single-port 32-bit memory, 2**ADDR_WD words, byte-lane write enables and a
//   registered read port. The array itself is not reset; only the read data
//   register is.
//   clk     in   clock, rising edge
//   rst_n   in   async active-low reset (read data register only)
//   we      in   4  byte write enables, lane i = wdata[8i+7:8i]
//   waddr   in   ADDR_WD  write word index
//   wdata   in   32 write data
//   re      in   read enable; loads rdata from mem[raddr]
//   raddr   in   ADDR_WD  read word index
//   rdata   out  32 registered read data, holds until the next read
// -----------------------------------------------------------------------------
module sram_bytewe #(
    parameter int unsigned ADDR_WD = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         we,
    input  logic [ADDR_WD-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic               re,
    input  logic [ADDR_WD-1:0] raddr,
    output logic [31:0]        rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WD;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Target end of the data_sram bus. Byte-writable data memory with a
//   configurable number of wait states per access; raises stallreq while an
//   access is outstanding.
//   clk      in   clock, rising edge
//   resetn   in   async active-low reset
//   bus      slave modport of data_sram_responder_if
//   ADDR_WD      word-address width (depth = 2**ADDR_WD words)
//   WAIT_CYCLES  extra cycles per access, 0..15 (0 = plain 1-cycle SRAM)
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WD     = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    data_sram_responder_if.slave   bus
);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    // Byte offset and address bits above the array alias away
    logic [ADDR_WD-1:0] word_idx;
    logic               unused_addr_bits;

    assign word_idx         = bus.data_sram_addr[ADDR_WD+1:2];
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_WD+2], bus.data_sram_addr[1:0]};

    // Operation presented to the array this cycle
    logic [3:0]         op_we;
    logic               op_re;
    logic [ADDR_WD-1:0] op_addr;
    logic [31:0]        op_wdata;

    if (WAIT_CYCLES == 0) begin : g_direct
        assign op_we         = bus.data_sram_en ? bus.data_sram_wen : '0;
        assign op_re         = bus.data_sram_en && is_read(bus.data_sram_wen);
        assign op_addr       = word_idx;
        assign op_wdata      = bus.data_sram_wdata;
        assign bus.stallreq  = NO_STOP;
    end else begin : g_waited
        dsram_state_e       state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        dsram_req_t         req_q, req_d;
        logic [ADDR_WD-1:0] addr_q, addr_d;
        logic               fire;
        logic               stall;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= DSRAM_IDLE;
                cnt_q   <= '0;
                req_q   <= '0;
                addr_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= req_d;
                addr_q  <= addr_d;
            end
        end

        // The request is still on the bus while BUSY (initiator holds it during
        // the stall); BUSY ignores the bus so the held copy is not re-executed.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            req_d   = req_q;
            addr_d  = addr_q;
            fire    = 1'b0;
            stall   = NO_STOP;
            unique case (state_q)
                DSRAM_IDLE: begin
                    stall = bus.data_sram_en ? STOP : NO_STOP;
                    if (bus.data_sram_en) begin
                        req_d   = '{wen: bus.data_sram_wen, wdata: bus.data_sram_wdata};
                        addr_d  = word_idx;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = DSRAM_BUSY;
                    end
                end
                DSRAM_BUSY: begin
                    stall = (cnt_q > CNT_W'(1)) ? STOP : NO_STOP;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fire    = 1'b1;
                        state_d = DSRAM_IDLE;
                    end
                end
                default: begin
                    state_d = DSRAM_IDLE;
                end
            endcase
        end

        assign op_we        = fire ? req_q.wen : '0;
        assign op_re        = fire && is_read(req_q.wen);
        assign op_addr      = addr_q;
        assign op_wdata     = req_q.wdata;
        assign bus.stallreq = stall;
    end

    sram_bytewe #(
        .ADDR_WD (ADDR_WD)
    ) u_sram (
        .clk   (clk),
        .rst_n (resetn),
        .we    (op_we),
        .waddr (op_addr),
        .wdata (op_wdata),
        .re    (op_re),
        .raddr (op_addr),
        .rdata (bus.data_sram_rdata)
    );

endmodule
